wb_vector_writer: RTL

//  Write-back stage behind the MEM/WB pipeline register. Consumes its output bundle
//  (sel_wb, reg_wrv, reg_wrs, MEM, DATA, dir_dest, data_wrs).

---
 rtl/wb_vector_writer_if.sv | 39 +++
 rtl/wb_vector_writer.sv | 89 ++++++++
 2 files changed

// File: rtl/wb_vector_writer_if.sv
// Write-back bundle in, vector/scalar register file writes and bypass out.
interface wb_vector_writer_if #(
    parameter int ELEM_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 3
);
    localparam int DATA_W = ELEM_W * LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic              sel_wb_in;
    logic              reg_wrv_in;
    logic              reg_wrs_in;
    logic [DATA_W-1:0] MEM_in;
    logic [DATA_W-1:0] DATA_in;
    logic [ADDR_W-1:0] dir_dest_in;
    logic [ELEM_W-1:0] data_wrs_in;
    logic              stall;
    logic              vrf_we;
    logic [ADDR_W-1:0] vrf_addr;
    logic [LANE_W-1:0] vrf_lane;
    logic [ELEM_W-1:0] vrf_wdata;
    logic              srf_we;
    logic [ELEM_W-1:0] srf_wdata;
    logic              byp_valid;
    logic [ADDR_W-1:0] byp_addr;
    logic [DATA_W-1:0] byp_data;

    modport slave (
        input  sel_wb_in, reg_wrv_in, reg_wrs_in, MEM_in, DATA_in, dir_dest_in, data_wrs_in,
        output stall, vrf_we, vrf_addr, vrf_lane, vrf_wdata, srf_we, srf_wdata,
               byp_valid, byp_addr, byp_data
    );

    modport master (
        output sel_wb_in, reg_wrv_in, reg_wrs_in, MEM_in, DATA_in, dir_dest_in, data_wrs_in,
        input  stall, vrf_we, vrf_addr, vrf_lane, vrf_wdata, srf_we, srf_wdata,
               byp_valid, byp_addr, byp_data
    );
endinterface

// File: rtl/wb_vector_writer.sv
// Write-back stage: serialises a vector result one element per cycle into the VRF and
// issues scalar writes. Optional full-vector bypass port enabled by WB_BYPASS_EN.
module wb_vector_writer #(
    parameter int ELEM_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               rst,
    wb_vector_writer_if.slave bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]                    state;
    logic [LANE_W-1:0]             lane;
    logic [LANE_W-1:0]             lane_nx;
    logic [LANES-1:0][ELEM_W-1:0]  hold;
    logic [LANES-1:0][ELEM_W-1:0]  result;
    logic                          take;
    logic                          load;

    // Only the last-lane cycle of a write can accept the next bundle.
    assign bus.stall = (state == WRITE) && (lane != LAST);
    assign take      = !bus.stall;
    assign load      = take && bus.reg_wrv_in;
    assign result    = bus.sel_wb_in ? bus.MEM_in : bus.DATA_in;
    assign lane_nx   = lane + LANE_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lane          <= '0;
            hold          <= '0;
            bus.vrf_we    <= 1'b0;
            bus.vrf_addr  <= '0;
            bus.vrf_lane  <= '0;
            bus.vrf_wdata <= '0;
            bus.srf_we    <= 1'b0;
            bus.srf_wdata <= '0;
        end else begin
            bus.srf_we <= take && bus.reg_wrs_in;
            if (take && bus.reg_wrs_in)
                bus.srf_wdata <= bus.data_wrs_in;

            // Element 0 goes out straight from the incoming result; hold feeds the rest.
            if (load) begin
                state         <= WRITE;
                lane          <= '0;
                hold          <= result;
                bus.vrf_we    <= 1'b1;
                bus.vrf_addr  <= bus.dir_dest_in;
                bus.vrf_lane  <= '0;
                bus.vrf_wdata <= result[0];
            end else if (bus.stall) begin
                lane          <= lane_nx;
                bus.vrf_lane  <= lane_nx;
                bus.vrf_wdata <= hold[lane_nx];
            end else begin
                state      <= IDLE;
                bus.vrf_we <= 1'b0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.byp_valid <= 1'b0;
            bus.byp_addr  <= '0;
            bus.byp_data  <= '0;
        end else if (load) begin
            bus.byp_valid <= 1'b1;
            bus.byp_addr  <= bus.dir_dest_in;
            bus.byp_data  <= result;
        end else if (take) begin
            bus.byp_valid <= 1'b0;
        end
    end
`else
    assign bus.byp_valid = 1'b0;
    assign bus.byp_addr  = '0;
    assign bus.byp_data  = '0;
`endif

endmodule
